// File: rtl/spi_dac_rx.sv
// Slave-side decoder for 24-bit AD56x8-style DAC frames on cs_n/sclk/mosi.
// Keeps input and DAC registers for channels A and B, mirroring the target DAC.
module spi_dac_rx #(
  parameter int          SYNC_STAGES = 0,
  parameter logic [11:0] RESET_CODE  = 12'h000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cs_n,
  input  logic        sclk,
  input  logic        mosi,
  output logic [11:0] dac_a,
  output logic [11:0] dac_b,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [3:0]  frame_cmd,
  output logic [3:0]  frame_addr,
  output logic [11:0] frame_data
);

  typedef struct packed {
    logic        ok;
    logic        err;
    logic [19:0] word;  // cmd, addr, data; trailing don't-care nibble dropped
  } frame_t;

  logic s_cs, s_sclk, s_mosi;

  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign s_cs   = cs_n;
      assign s_sclk = sclk;
      assign s_mosi = mosi;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] cs_q, sclk_q, mosi_q;
      // cs chain resets low so its flush after reset is seen as an ignored fall
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          cs_q   <= '0;
          sclk_q <= '0;
          mosi_q <= '0;
        end else begin
          cs_q[0]   <= cs_n;
          sclk_q[0] <= sclk;
          mosi_q[0] <= mosi;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            cs_q[i]   <= cs_q[i-1];
            sclk_q[i] <= sclk_q[i-1];
            mosi_q[i] <= mosi_q[i-1];
          end
        end
      end
      assign s_cs   = cs_q[SYNC_STAGES-1];
      assign s_sclk = sclk_q[SYNC_STAGES-1];
      assign s_mosi = mosi_q[SYNC_STAGES-1];
    end
  endgenerate

  logic        prev_cs, prev_sclk, armed, in_frame;
  logic [4:0]  cnt;
  logic [23:0] sr;
  frame_t      stg0, stg1;
  logic        fall, rise, srise, start;

  assign fall  = prev_cs & ~s_cs;
  assign rise  = ~prev_cs & s_cs;
  assign srise = ~prev_sclk & s_sclk;
  // armed keeps a frame already in flight at reset release from being decoded
  assign start = fall & armed;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_cs   <= 1'b1;
      prev_sclk <= 1'b0;
      armed     <= 1'b0;
      in_frame  <= 1'b0;
      cnt       <= '0;
      sr        <= '0;
      stg0      <= '0;
      stg1      <= '0;
    end else begin
      prev_cs   <= s_cs;
      prev_sclk <= s_sclk;
      armed     <= armed | s_cs;
      stg0.ok   <= in_frame && rise && (cnt == 5'd24);
      stg0.err  <= in_frame && rise && (cnt != 5'd24);
      stg0.word <= sr[23:4];
      stg1      <= stg0;
      if (start) begin
        in_frame <= 1'b1;
        cnt      <= {4'd0, srise};
        sr       <= {23'd0, srise & s_mosi};
      end else if (in_frame && !s_cs && srise) begin
        sr <= {sr[22:0], s_mosi};
        if (cnt != 5'd31) cnt <= cnt + 5'd1;
      end else if (in_frame && rise) begin
        in_frame <= 1'b0;
      end
    end
  end

  logic [3:0]  cmd, addr;
  logic [11:0] data;
  logic        sel_a, sel_b;
  logic [11:0] in_a, in_b, in_a_nx, in_b_nx, dac_a_nx, dac_b_nx;

  assign cmd   = stg1.word[19:16];
  assign addr  = stg1.word[15:12];
  assign data  = stg1.word[11:0];
  assign sel_a = (addr == 4'h0) || (addr == 4'hF);
  assign sel_b = (addr == 4'h1) || (addr == 4'hF);

  // updates read the post-write input value so write+update needs no extra clk
  always_comb begin
    in_a_nx  = in_a;
    in_b_nx  = in_b;
    dac_a_nx = dac_a;
    dac_b_nx = dac_b;
    if (stg1.ok) begin
      if (cmd == 4'h0 || cmd == 4'h2 || cmd == 4'h3) begin
        if (sel_a) in_a_nx = data;
        if (sel_b) in_b_nx = data;
      end
      if (cmd == 4'h2) begin
        dac_a_nx = in_a_nx;
        dac_b_nx = in_b_nx;
      end
      if (cmd == 4'h1 || cmd == 4'h3) begin
        if (sel_a) dac_a_nx = in_a_nx;
        if (sel_b) dac_b_nx = in_b_nx;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_a        <= RESET_CODE;
      in_b        <= RESET_CODE;
      dac_a       <= RESET_CODE;
      dac_b       <= RESET_CODE;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      frame_cmd   <= '0;
      frame_addr  <= '0;
      frame_data  <= '0;
    end else begin
      in_a        <= in_a_nx;
      in_b        <= in_b_nx;
      dac_a       <= dac_a_nx;
      dac_b       <= dac_b_nx;
      frame_valid <= stg1.ok;
      frame_err   <= stg1.err;
      if (stg1.ok) begin
        frame_cmd  <= cmd;
        frame_addr <= addr;
        frame_data <= data;
      end
    end
  end

endmodule

// File: tb/tb_spi_dac_rx.sv
// Bench for spi_dac_rx: a direct-sampled instance driven at clk/2 and a
// double-synchronised instance driven by an unrelated clk/6 sclk.
module tb_spi_dac_rx;
  logic clk, rstn;
  logic cs0, sclk0, mosi0, cs2, sclk2, mosi2;
  logic [11:0] d0_dac_a, d0_dac_b, d0_data, d2_dac_a, d2_dac_b, d2_data;
  logic        d0_valid, d0_err, d2_valid, d2_err;
  logic [3:0]  d0_cmd, d0_addr, d2_cmd, d2_addr;

  spi_dac_rx #(.SYNC_STAGES(0), .RESET_CODE(12'h000)) dut0 (
    .clk(clk), .rstn(rstn), .cs_n(cs0), .sclk(sclk0), .mosi(mosi0),
    .dac_a(d0_dac_a), .dac_b(d0_dac_b), .frame_valid(d0_valid), .frame_err(d0_err),
    .frame_cmd(d0_cmd), .frame_addr(d0_addr), .frame_data(d0_data));

  spi_dac_rx #(.SYNC_STAGES(2), .RESET_CODE(12'h000)) dut2 (
    .clk(clk), .rstn(rstn), .cs_n(cs2), .sclk(sclk2), .mosi(mosi2),
    .dac_a(d2_dac_a), .dac_b(d2_dac_b), .frame_valid(d2_valid), .frame_err(d2_err),
    .frame_cmd(d2_cmd), .frame_addr(d2_addr), .frame_data(d2_data));

  initial clk = 0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_valid0 = 0, n_err0 = 0, n_both0 = 0, n_valid2 = 0, n_err2 = 0;
  always @(negedge clk) begin
    if (d0_valid) n_valid0++;
    if (d0_err) n_err0++;
    if (d0_valid && d0_err) n_both0++;
    if (d2_valid) n_valid2++;
    if (d2_err) n_err2++;
  end

  int tests = 0, fails = 0;

  // reference model of dut0: channel 0 = A, channel 1 = B
  logic [11:0] m_in [2];
  logic [11:0] m_dac [2];
  logic [3:0]  m_cmd, m_addr;
  logic [11:0] m_data;
  int e_valid0 = 0, e_err0 = 0;

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin m_in[c] = 12'h000; m_dac[c] = 12'h000; end
    m_cmd = 0; m_addr = 0; m_data = 0;
  endtask

  task automatic model_frame(input int nbits, input logic [23:0] w);
    logic [3:0] cmd, addr;
    logic [11:0] data;
    bit sel [2];
    cmd = w[23:20]; addr = w[19:16]; data = w[15:4];
    if (nbits != 24) begin e_err0++; return; end
    e_valid0++;
    m_cmd = cmd; m_addr = addr; m_data = data;
    for (int c = 0; c < 2; c++) sel[c] = (int'(addr) == c) || (addr == 4'hF);
    for (int c = 0; c < 2; c++) begin
      case (cmd)
        4'h0: if (sel[c]) m_in[c] = data;
        4'h1: if (sel[c]) m_dac[c] = m_in[c];
        4'h2: begin if (sel[c]) m_in[c] = data; m_dac[c] = m_in[c]; end
        4'h3: if (sel[c]) begin m_in[c] = data; m_dac[c] = data; end
        default: ;
      endcase
    end
  endtask

  // clk/2 frame on dut0; fast puts the first sclk rise on the cs_n fall clk
  task automatic send0(input int nbits, input logic [23:0] w, input bit fast, output int t_hi);
    logic b;
    @(posedge clk); #1;
    cs0 = 0;
    for (int i = 0; i < nbits; i++) begin
      b = (i < 24) ? w[23-i] : 1'($urandom);
      if (i == 0 && fast) begin
        mosi0 = b; sclk0 = 1;
      end else begin
        @(posedge clk); #1 sclk0 = 0; mosi0 = b;
        @(posedge clk); #1 sclk0 = 1;
      end
    end
    if (nbits == 0) repeat (4) @(posedge clk);
    @(posedge clk); #1 sclk0 = 0;
    @(posedge clk); #1 cs0 = 1; mosi0 = 0;
    t_hi = cyc + 1;
  endtask

  task automatic wait_cyc(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  task automatic settle();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 0; cs0 = 1; sclk0 = 0; mosi0 = 0; cs2 = 1; sclk2 = 0; mosi2 = 0;
    repeat (3) @(posedge clk);
    #1 rstn = 1;
    model_reset();
    settle();
    tests++; if (d0_dac_a !== 12'h000) begin fails++; $display("FAIL reset_dac_a got %h want 000", d0_dac_a); end
    tests++; if (d0_dac_b !== 12'h000) begin fails++; $display("FAIL reset_dac_b got %h want 000", d0_dac_b); end
    tests++; if ({d0_cmd, d0_addr, d0_data} !== 20'h0) begin fails++; $display("FAIL reset_frame got %h want 0", {d0_cmd, d0_addr, d0_data}); end
    tests++; if ({d0_valid, d0_err, d2_valid, d2_err} !== 4'b0) begin fails++; $display("FAIL reset_pulses got %b want 0000", {d0_valid, d0_err, d2_valid, d2_err}); end
    tests++; if (n_err0 + n_err2 + n_valid0 + n_valid2 !== 0) begin fails++; $display("FAIL reset_no_events got %0d want 0", n_err0 + n_err2 + n_valid0 + n_valid2); end
  endtask

  task automatic test_write_input();
    int t;
    send0(24, {4'h0, 4'h0, 12'hABC, 4'h0}, 0, t);
    model_frame(24, {4'h0, 4'h0, 12'hABC, 4'h0});
    wait_cyc(t + 2);
    tests++; if (d0_valid !== 1'b1) begin fails++; $display("FAIL wr_valid_pulse got %b want 1", d0_valid); end
    @(negedge clk);
    tests++; if (d0_valid !== 1'b0) begin fails++; $display("FAIL wr_valid_one_clk got %b want 0", d0_valid); end
    tests++; if ({d0_cmd, d0_addr, d0_data} !== 20'h00ABC) begin fails++; $display("FAIL wr_fields got %h want 00abc", {d0_cmd, d0_addr, d0_data}); end
    tests++; if ({d0_dac_a, d0_dac_b} !== 24'h000000) begin fails++; $display("FAIL wr_dacs_hold got %h want 000000", {d0_dac_a, d0_dac_b}); end
  endtask

  task automatic test_update_all();
    int t;
    send0(24, {4'h2, 4'h1, 12'h123, 4'h0}, 0, t);
    model_frame(24, {4'h2, 4'h1, 12'h123, 4'h0});
    wait_cyc(t + 1);
    tests++; if ({d0_valid, d0_dac_a, d0_dac_b} !== 25'h0) begin fails++; $display("FAIL upd_early got %h want 0", {d0_valid, d0_dac_a, d0_dac_b}); end
    wait_cyc(t + 2);
    tests++; if ({d0_valid, d0_dac_a, d0_dac_b} !== {1'b1, 12'hABC, 12'h123}) begin fails++; $display("FAIL upd_latency got %h want 1abc123", {d0_valid, d0_dac_a, d0_dac_b}); end
  endtask

  task automatic test_write_update();
    int t;
    send0(24, {4'h3, 4'hF, 12'hFFF, 4'h0}, 0, t);
    model_frame(24, {4'h3, 4'hF, 12'hFFF, 4'h0});
    settle();
    tests++; if ({d0_dac_a, d0_dac_b} !== 24'hFFFFFF) begin fails++; $display("FAIL wu_both got %h want ffffff", {d0_dac_a, d0_dac_b}); end
    send0(24, {4'h1, 4'h0, 12'h000, 4'h0}, 0, t);
    model_frame(24, {4'h1, 4'h0, 12'h000, 4'h0});
    settle();
    tests++; if ({d0_dac_a, d0_dac_b} !== 24'hFFFFFF) begin fails++; $display("FAIL wu_update_keeps got %h want ffffff", {d0_dac_a, d0_dac_b}); end
    tests++; if (n_valid0 !== e_valid0) begin fails++; $display("FAIL wu_valid_count got %0d want %0d", n_valid0, e_valid0); end
  endtask

  task automatic test_bad_frames();
    int t, v0, e0;
    int nb [3] = '{23, 30, 0};
    for (int k = 0; k < 3; k++) begin
      v0 = n_valid0; e0 = n_err0;
      send0(nb[k], {4'h3, 4'hF, 12'h111, 4'h0}, 0, t);
      model_frame(nb[k], {4'h3, 4'hF, 12'h111, 4'h0});
      settle();
      tests++; if (n_err0 - e0 !== 1) begin fails++; $display("FAIL bad_err_%0d got %0d want 1", nb[k], n_err0 - e0); end
      tests++; if (n_valid0 - v0 !== 0) begin fails++; $display("FAIL bad_novalid_%0d got %0d want 0", nb[k], n_valid0 - v0); end
      tests++; if ({d0_dac_a, d0_dac_b} !== 24'hFFFFFF) begin fails++; $display("FAIL bad_hold_%0d got %h want ffffff", nb[k], {d0_dac_a, d0_dac_b}); end
    end
  endtask

  task automatic test_reset_midframe();
    int t, v0, e0, e2;
    logic [23:0] w;
    w = {4'h3, 4'hF, 12'h999, 4'h0};
    v0 = n_valid0; e0 = n_err0; e2 = n_err2;
    @(posedge clk); #1 cs0 = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1 sclk0 = 0; mosi0 = w[23-i];
      @(posedge clk); #1 sclk0 = 1;
    end
    @(posedge clk); #1 rstn = 0; sclk0 = 0;
    repeat (2) @(posedge clk);
    #1 rstn = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 cs0 = 1;
    settle();
    tests++; if ({d0_dac_a, d0_dac_b} !== 24'h000000) begin fails++; $display("FAIL rmf_dacs got %h want 000000", {d0_dac_a, d0_dac_b}); end
    tests++; if (n_valid0 - v0 !== 0) begin fails++; $display("FAIL rmf_novalid got %0d want 0", n_valid0 - v0); end
    tests++; if (n_err0 - e0 !== 0) begin fails++; $display("FAIL rmf_noerr got %0d want 0", n_err0 - e0); end
    tests++; if (n_err2 - e2 !== 0) begin fails++; $display("FAIL rmf_sync_noerr got %0d want 0", n_err2 - e2); end
    e_valid0 = n_valid0; e_err0 = n_err0;
    send0(24, {4'h3, 4'h0, 12'h7E1, 4'h0}, 0, t);
    model_frame(24, {4'h3, 4'h0, 12'h7E1, 4'h0});
    settle();
    tests++; if ({d0_dac_a, d0_dac_b} !== 24'h7E1000) begin fails++; $display("FAIL rmf_next_frame got %h want 7e1000", {d0_dac_a, d0_dac_b}); end
  endtask

  task automatic test_random();
    int t, nbits;
    logic [3:0] cmd, addr;
    logic [23:0] w;
    bit fast;
    for (int k = 0; k < 24; k++) begin
      cmd = 4'($urandom_range(0, 5));
      case ($urandom_range(0, 3))
        0: addr = 4'h0;
        1: addr = 4'h1;
        2: addr = 4'hF;
        default: addr = 4'($urandom);
      endcase
      w = {cmd, addr, 12'($urandom), 4'($urandom)};
      nbits = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 35) : 24;
      fast = 1'($urandom);
      if (nbits == 0) fast = 0;
      send0(nbits, w, fast, t);
      model_frame(nbits, w);
      settle();
      tests++;
      if ({d0_dac_a, d0_dac_b, d0_cmd, d0_addr, d0_data} !== {m_dac[0], m_dac[1], m_cmd, m_addr, m_data}) begin
        fails++;
        $display("FAIL rand_%0d state got %h want %h", k, {d0_dac_a, d0_dac_b, d0_cmd, d0_addr, d0_data},
                 {m_dac[0], m_dac[1], m_cmd, m_addr, m_data});
      end
      tests++;
      if (n_valid0 !== e_valid0 || n_err0 !== e_err0) begin
        fails++;
        $display("FAIL rand_%0d counts got v%0d e%0d want v%0d e%0d", k, n_valid0, n_err0, e_valid0, e_err0);
      end
    end
    tests++; if (n_both0 !== 0) begin fails++; $display("FAIL valid_err_exclusive got %0d want 0", n_both0); end
  endtask

  task automatic test_sync2();
    int t;
    logic [23:0] w;
    w = {4'h2, 4'h0, 12'h5A5, 4'h0};
    @(posedge clk); #3;
    cs2 = 0; #30;
    for (int i = 0; i < 24; i++) begin
      sclk2 = 0; mosi2 = w[23-i]; #30;
      sclk2 = 1; #30;
    end
    sclk2 = 0; #30;
    cs2 = 1; mosi2 = 0;
    t = cyc + 1;
    wait_cyc(t + 3);
    tests++; if ({d2_valid, d2_dac_a} !== 13'h0) begin fails++; $display("FAIL sync_early got %h want 0", {d2_valid, d2_dac_a}); end
    wait_cyc(t + 4);
    tests++; if ({d2_valid, d2_dac_a, d2_dac_b} !== {1'b1, 12'h5A5, 12'h000}) begin fails++; $display("FAIL sync_latency got %h want 15a5000", {d2_valid, d2_dac_a, d2_dac_b}); end
    settle();
    tests++; if ({n_valid2, n_err2} !== {32'd1, 32'd0}) begin fails++; $display("FAIL sync_counts got v%0d e%0d want v1 e0", n_valid2, n_err2); end
  endtask

  initial begin
    test_reset();
    test_write_input();
    test_update_all();
    test_write_update();
    test_bad_frames();
    test_reset_midframe();
    test_random();
    test_sync2();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
